// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first adder built from one full-adder cell and a
// carry flip-flop. Operands are captured on an accepted start, one bit is added
// per clock, and sum/cout are published together with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a `sub` input that turns
// the operation into a - b, with cout reporting the borrow.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             carry;
    logic [CW-1:0]    count;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] shifted;
    logic             bit_sum;
    logic             bit_carry;
    logic             sub_in;
    logic             sub_q;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;

    // Remember the operation kind so the final carry can be reported as a borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sub_q <= 1'b0;
        else if (load) sub_q <= sub_in;
    end
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    // The single full-adder cell, fed by the operand LSBs and the carry FF.
    assign bit_sum   = ra[0] ^ rb[0] ^ carry;
    assign bit_carry = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    // New sum bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
    assign shifted   = {bit_sum, sum_sr};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath control decode.
    // NOTE: every output of this block gets a default first so no latch is inferred
    // on paths that do not assign it.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST_BIT) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // Operand shift registers, carry FF, bit counter and result registers.
    // NOTE: all datapath registers are reset, including the shift registers, so an
    // aborted operation leaves no stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_sr <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            ra    <= a;
            // Subtraction is a + ~b + 1: invert b and preset the carry.
            rb    <= sub_in ? ~b : b;
            carry <= sub_in;
            count <= '0;
        end else if (step) begin
            ra     <= ra >> 1;
            rb     <= rb >> 1;
            carry  <= bit_carry;
            sum_sr <= shifted[WIDTH-1:1];
            count  <= count + 1'b1;
            // Publish only the complete result so partial sums are never visible.
            if (last) begin
                sum  <= shifted;
                cout <= sub_q ? ~bit_carry : bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8). Directed and
// random operations are compared against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry/borrow, result} from plain arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = x - y;
            r[W]     = (x < y);
        end else begin
            r = {1'b0, x} + {1'b0, y};
        end
        return r;
    endfunction

    // Issue one operation and wait for done. lat = edges from the sampling edge to
    // the edge that raises done; bcnt = cycles with busy high; held = sum never moved
    // before done. Optionally scrambles the operand inputs while the op runs.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input bit scramble, output int lat, output int bcnt,
                          output bit held, output bit timeout);
        logic [W-1:0] prev;
        prev = sum;
        @(negedge clk);
        a = x;
        b = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`endif
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lat     = 0;
        bcnt    = 0;
        held    = 1'b1;
        timeout = 1'b0;
        while (!done && lat < 4 * W) begin
            if (busy) bcnt++;
            if (sum !== prev) held = 1'b0;
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
                sub = 1'($urandom);
`endif
            end
            @(negedge clk);
            lat++;
        end
        if (lat >= 4 * W) timeout = 1'b1;
        if (s) begin end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, cout} !== '0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat, bcnt;
        bit held, to;
        logic [W:0] exp;
        logic [W-1:0] xs [2] = '{8'h35, 8'hFF};
        logic [W-1:0] ys [2] = '{8'h1A, 8'h01};
        for (int i = 0; i < 2; i++) begin
            exp = model(xs[i], ys[i], 1'b0);
            run_op(xs[i], ys[i], 1'b0, 1'b0, lat, bcnt, held, to);
            total++;
            if (to || lat != W) begin
                bad++;
                $display("FAIL latency %h+%h: got %0d edges (timeout=%b), required %0d", xs[i], ys[i], lat, to, W);
            end
            total++;
            if ({cout, sum} !== exp) begin
                bad++;
                $display("FAIL result %h+%h: got cout=%b sum=%h, required cout=%b sum=%h", xs[i], ys[i], cout, sum, exp[W], exp[W-1:0]);
            end
            total++;
            if (bcnt != W) begin
                bad++;
                $display("FAIL busy_len %h+%h: got %0d cycles, required %0d", xs[i], ys[i], bcnt, W);
            end
            total++;
            if (!held) begin
                bad++;
                $display("FAIL sum_held %h+%h: sum changed before done, required held", xs[i], ys[i]);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || sum !== exp[W-1:0]) begin
                bad++;
                $display("FAIL done_pulse %h+%h: done=%b sum=%h one cycle later, required done=0 sum=%h", xs[i], ys[i], done, sum, exp[W-1:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        logic [W-1:0] got_sum;
        logic got_cout;
        logic [W:0] exp;
        exp = model(8'h5A, 8'h33, 1'b0);
        pulses = 0;
        got_sum = '0;
        got_cout = 1'b0;
        @(negedge clk);
        a = 8'h5A;
        b = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        start = 1'b1;
        for (int k = 0; k < 2 * W; k++) begin
            if (k == 2) start = 1'b0;
            if (done) begin
                pulses++;
                got_sum  = sum;
                got_cout = cout;
            end
            @(negedge clk);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL ignore_start pulses: got %0d, required 1", pulses);
        end
        total++;
        if ({got_cout, got_sum} !== exp) begin
            bad++;
            $display("FAIL ignore_start result: got cout=%b sum=%h, required cout=%b sum=%h", got_cout, got_sum, exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int t [2];
        logic [W:0] r [2];
        int n;
        logic [W:0] exp0, exp1;
        exp0 = model(8'hC3, 8'h7E, 1'b0);
        exp1 = model(8'h11, 8'h22, 1'b0);
        n = 0;
        @(negedge clk);
        a = 8'hC3;
        b = 8'h7E;
        start = 1'b1;
        @(negedge clk);
        // First op captured; these values must only reach the second op.
        a = 8'h11;
        b = 8'h22;
        k = 0;
        while (n < 2 && k < 6 * W) begin
            if (done) begin
                t[n] = k;
                r[n] = {cout, sum};
                n++;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL back_to_back: got %0d done pulses in budget, required 2", n);
        end else begin
            total++;
            if (t[1] - t[0] != W + 2) begin
                bad++;
                $display("FAIL back_to_back spacing: got %0d cycles, required %0d", t[1] - t[0], W + 2);
            end
            total++;
            if (r[0] !== exp0 || r[1] !== exp1) begin
                bad++;
                $display("FAIL back_to_back results: got %h,%h required %h,%h", r[0], r[1], exp0, exp1);
            end
        end
        repeat (W + 3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt, pulses;
        bit held, to;
        @(negedge clk);
        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum, cout} !== '0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_run activity: got %0d busy/done cycles after abort, required 0", pulses);
        end
        run_op(8'h80, 8'h80, 1'b0, 1'b0, lat, bcnt, held, to);
        total++;
        if (to || {cout, sum} !== 9'h100) begin
            bad++;
            $display("FAIL after_reset 80+80: got cout=%b sum=%h (timeout=%b), required cout=1 sum=00", cout, sum, to);
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        bit held, to;
        logic [W-1:0] x, y;
        logic s;
        logic [W:0] exp;
        for (int i = 0; i < 24; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            if (i == 0) begin x = 8'hFF; y = 8'hFF; end
            if (i == 1) begin x = 8'h00; y = 8'h00; end
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            exp = model(x, y, s);
            run_op(x, y, s, 1'b1, lat, bcnt, held, to);
            total++;
            if (to || lat != W || {cout, sum} !== exp) begin
                bad++;
                $display("FAIL random %0d %h %s %h: got cout=%b sum=%h lat=%0d, required cout=%b sum=%h lat=%0d",
                         i, x, s ? "-" : "+", y, cout, sum, lat, exp[W], exp[W-1:0], W);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat, bcnt;
        bit held, to;
        logic [W:0] exp;
        logic [W-1:0] xs [2] = '{8'h05, 8'h07};
        logic [W-1:0] ys [2] = '{8'h07, 8'h05};
        for (int i = 0; i < 2; i++) begin
            exp = model(xs[i], ys[i], 1'b1);
            run_op(xs[i], ys[i], 1'b1, 1'b0, lat, bcnt, held, to);
            total++;
            if (to || {cout, sum} !== exp) begin
                bad++;
                $display("FAIL sub %h-%h: got borrow=%b sum=%h, required borrow=%b sum=%h", xs[i], ys[i], cout, sum, exp[W], exp[W-1:0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
